array_rw_ctrl: RTL and testbench
================================

ARRAY_RW_CTRL -- requirements
Module: array_rw_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of SRAM entries.
REQ-002 SHALL have parameter ADDR_W, default 8, address width (log2 DEPTH).
REQ-003 SHALL have parameters LANES, default 4, and LANE_W, default 43, so that DATA_W = LANES*LANE_W = 172.
REQ-004 SHALL have parameter INIT_ZERO, default 1; when 1, all entries are zeroed after reset.
REQ-005 SHALL have port clock, in, 1, sole clock.
REQ-006 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-007 SHALL have ports req_valid in 1, req_ready out 1, req_write in 1, req_addr in ADDR_W, req_wmask in LANES, req_wdata in DATA_W; together these form the upstream request.
REQ-008 SHALL have ports resp_valid out 1, resp_ready in 1, resp_rdata out DATA_W; together these form the read response.
REQ-009 SHALL have ports sram_en out 1, sram_wmode out 1, sram_addr out ADDR_W, sram_wmask out LANES, sram_wdata out DATA_W, sram_rdata in DATA_W; these drive a single-port SRAM macro with 1-cycle read latency and per-lane write mask.
REQ-010 SHALL have port init_done, out, 1; high once initialization is complete.

Function
REQ-011 SHALL implement FSM states INIT and RUN: reset -> INIT if INIT_ZERO=1, else RUN; INIT -> RUN after the write to entry DEPTH-1.
REQ-012 In INIT, SHALL drive sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0 and sram_addr=init counter, with the counter running 0..DEPTH-1, one entry per cycle.
REQ-013 SHALL hold req_ready=0 in INIT; init_done SHALL rise in the cycle after the last init write (cycle DEPTH after reset release) and stay high until reset.
REQ-014 In RUN, a request SHALL be accepted on req_valid && req_ready; the SRAM port SHALL be driven combinationally in that same cycle (no request register).
REQ-015 An accepted write SHALL drive sram_en=1 and sram_wmode=1 with req_addr, req_wmask and req_wdata; it produces no response.
REQ-016 A write with wmask=0 SHALL be accepted with sram_en=0.
REQ-017 An accepted read SHALL drive sram_en=1 and sram_wmode=0, and SHALL set an inflight flag for the next cycle.
REQ-018 When the inflight flag is set, sram_rdata SHALL be pushed into a 3-entry response FIFO at the end of that cycle.
REQ-019 SHALL drive resp_valid high whenever the FIFO is non-empty; resp_rdata SHALL be the FIFO head, and it is popped on resp_valid && resp_ready.
REQ-020 Read latency SHALL be: accepted in cycle N, resp_valid no earlier than cycle N+2.
REQ-021 req_ready SHALL be registered-state only (no path from resp_ready or req_valid); in RUN it SHALL be high when fifo_count + inflight < 3.
REQ-022 The credit rule of REQ-021 SHALL sustain one read per cycle indefinitely when resp_ready=1.
REQ-023 Reads and writes SHALL share the same req_ready; writes SHALL NOT bypass a stalled read condition (ordering preserved).
REQ-024 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged, and the FIFO SHALL never overflow; overflow is a bench assertion.
REQ-025 While idle, sram_en SHALL be 0; sram_addr, sram_wmask and sram_wdata are don't-care whenever sram_en=0.
REQ-026 Read-after-write to the same address in consecutive cycles SHALL return the new data (SRAM write-first ordering across cycles).

Reset
REQ-027 reset SHALL be synchronous, active-high, and take effect in any state, including mid-INIT or with reads in flight.
REQ-028 On reset, the module SHALL clear the FIFO, clear the inflight flag, set init counter=0, init_done=0, resp_valid=0, req_ready=0 and sram_en=0 during the reset cycle; data in flight is discarded.
REQ-029 SRAM contents SHALL NOT be assumed preserved or cleared by reset itself; only INIT clears them.

Structure
REQ-030 A shared package SHALL hold the DEPTH, ADDR_W, LANES and LANE_W defaults and the state enum {INIT, RUN}.
REQ-031 The response FIFO SHALL be one sub-module, resp_fifo (parameterized width and depth 3, valid/ready both ends); everything else is inline.

Verification
REQ-032 Bench SHALL cover: reset release with INIT_ZERO=1 -> 256 consecutive writes to addrs 0..255 with data 0 and mask 4'hF, init_done high at cycle 256, req_ready high from then.
REQ-033 Bench SHALL cover: write addr 0x12 data D, mask 4'b0101, onto a zeroed entry, then read 0x12 -> resp_rdata has lanes 0 and 2 from D and lanes 1 and 3 zero, resp_valid 2 cycles after read accept.
REQ-034 Bench SHALL cover: 100 back-to-back reads with resp_ready=1 -> 100 responses in order, req_ready never drops after the first read.
REQ-035 Bench SHALL cover: resp_ready=0 with continuous reads -> exactly 3 reads accepted, then req_ready=0; releasing resp_ready drains 3 responses in order and acceptance resumes.
REQ-036 Bench SHALL cover: reset asserted at init counter 100 with 2 reads outstanding in RUN -> FIFO empty, resp_valid=0, INIT restarts at addr 0.
REQ-037 Bench SHALL cover: write then read of addr 0xFF in consecutive cycles -> new data returned; write with wmask=0 -> sram_en stays 0.

Source files
------------

// File: rtl/array_rw_ctrl_pkg.sv
// Shared definitions for the array read/write controller.
//   - Default geometry of the SRAM array (entries, address width, lanes).
//   - Controller state encoding.
//   - Depth of the read-response FIFO, which also sets the number of read credits.
package array_rw_ctrl_pkg;

    localparam int DEPTH_DEF       = 256;
    localparam int ADDR_W_DEF      = 8;
    localparam int LANES_DEF       = 4;
    localparam int LANE_W_DEF      = 43;

    // Reads outstanding (in flight plus buffered) never exceed this.
    localparam int RESP_FIFO_DEPTH = 3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/array_rw_ctrl_resp_fifo.sv
// resp_fifo: small synchronous FIFO holding read responses.
// Ports:
//   clock, reset                - clock and synchronous active-high reset
//   in_valid/in_ready/in_data   - push side
//   out_valid/out_ready/out_data- pop side; out_data is the current head
//   count                       - current occupancy
// A push and a pop in the same cycle leave the occupancy unchanged.
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic push;
    logic pop;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign out_data  = mem[rd_ptr_reg];
    assign count     = count_reg;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Storage carries no reset; only the pointers and occupancy matter.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/array_rw_ctrl.sv
// array_rw_ctrl: front end for a single-port SRAM macro (1-cycle read latency,
// per-lane write mask).
// Ports:
//   clock, reset          - sole clock, synchronous active-high reset
//   req_valid/req_ready   - upstream request handshake
//   req_write, req_addr, req_wmask, req_wdata - request payload
//   resp_valid/resp_ready/resp_rdata          - read response stream
//   sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, sram_rdata
//                         - SRAM macro port, driven combinationally
//   init_done             - high once the optional zero-fill has finished
// After reset the array is optionally zero-filled one entry per cycle (INIT),
// then requests are passed straight to the SRAM (RUN). Read data returning
// from the SRAM is buffered in a 3-entry FIFO; a credit check keeps the sum of
// buffered and in-flight reads within the FIFO capacity so it never overflows.
module array_rw_ctrl
    import array_rw_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int LANE_W    = LANE_W_DEF,
    parameter int INIT_ZERO = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [LANES-1:0]          req_wmask,
    input  logic [LANES*LANE_W-1:0]   req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [LANES*LANE_W-1:0]   resp_rdata,
    output logic                      sram_en,
    output logic                      sram_wmode,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [LANES-1:0]          sram_wmask,
    output logic [LANES*LANE_W-1:0]   sram_wdata,
    input  logic [LANES*LANE_W-1:0]   sram_rdata,
    output logic                      init_done
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int CNT_W  = $clog2(RESP_FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam state_t RESET_STATE = (INIT_ZERO != 0) ? INIT : RUN;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] init_cnt_reg;
    logic [ADDR_W-1:0] init_cnt_next;
    logic              inflight_reg;
    logic              inflight_next;

    logic              fifo_in_ready;
    logic              fifo_out_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    pending;
    logic              credit_ok;
    logic              accept;

    // Credits depend only on registered state, so req_ready never combines
    // with req_valid or resp_ready. A read accepted now lands in the FIFO at
    // the end of the next cycle, hence in-flight reads count as occupied.
    assign pending   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    assign credit_ok = fifo_in_ready && (pending < (CNT_W + 1)'(RESP_FIFO_DEPTH));

    // Writes share the same credit gate so they cannot overtake stalled reads.
    assign req_ready = !reset && (state_reg == RUN) && credit_ok;
    assign accept    = req_valid && req_ready;

    assign init_done  = !reset && (state_reg == RUN);
    assign resp_valid = !reset && fifo_out_valid;

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        inflight_next = 1'b0;
        sram_en       = 1'b0;
        sram_wmode    = 1'b0;
        sram_addr     = req_addr;
        sram_wmask    = req_wmask;
        sram_wdata    = req_wdata;

        case (state_reg)
            INIT: begin
                sram_en       = 1'b1;
                sram_wmode    = 1'b1;
                sram_addr     = init_cnt_reg;
                sram_wmask    = '1;
                sram_wdata    = '0;
                init_cnt_next = init_cnt_reg + 1'b1;
                if (init_cnt_reg == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (req_write) begin
                        // An all-zero mask is consumed without touching the SRAM.
                        sram_en    = |req_wmask;
                        sram_wmode = 1'b1;
                    end else begin
                        sram_en       = 1'b1;
                        inflight_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase

        if (reset) begin
            sram_en = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= RESET_STATE;
            init_cnt_reg <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            inflight_reg <= inflight_next;
        end
    end

    resp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (inflight_reg),
        .in_ready  (fifo_in_ready),
        .in_data   (sram_rdata),
        .out_valid (fifo_out_valid),
        .out_ready (resp_ready),
        .out_data  (resp_rdata),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_array_rw_ctrl.sv
// Directed bench for array_rw_ctrl with a behavioural SRAM model and a
// response scoreboard (expected read data queued at accept, compared at pop).
module tb_array_rw_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int LANES  = 4;
    localparam int LANE_W = 43;
    localparam int DATA_W = LANES * LANE_W;

    typedef logic [DATA_W-1:0] data_t;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LANES-1:0]  req_wmask;
    data_t             req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    data_t             resp_rdata;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [LANES-1:0]  sram_wmask;
    data_t             sram_wdata;
    data_t             sram_rdata;
    logic              init_done;

    array_rw_ctrl #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .LANES     (LANES),
        .LANE_W    (LANE_W),
        .INIT_ZERO (1)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .init_done  (init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- SRAM model: never-written entries read back as garbage
    data_t sram_mem [DEPTH];
    bit    written  [DEPTH];

    function automatic data_t garbage(input logic [ADDR_W-1:0] a);
        logic [LANE_W-1:0] g;
        g = 43'h2A5A5A5A5A5 ^ LANE_W'(a);
        return {LANES{g}};
    endfunction

    always @(posedge clock) begin : sram_model
        data_t cur;
        if (sram_en) begin
            cur = written[sram_addr] ? sram_mem[sram_addr] : garbage(sram_addr);
            if (sram_wmode) begin
                for (int l = 0; l < LANES; l++) begin
                    if (sram_wmask[l]) begin
                        cur[l*LANE_W +: LANE_W] = sram_wdata[l*LANE_W +: LANE_W];
                    end
                end
                sram_mem[sram_addr] <= cur;
                written[sram_addr]  <= 1'b1;
            end else begin
                sram_rdata <= cur;
            end
        end
    end

    // ---------------- scoreboard state
    data_t ref_mem [DEPTH];
    data_t exp_q [$];
    int    n_checks;
    int    n_pass;
    int    rd_accepts;
    int    resp_count;

    task automatic chk(input string tag, input data_t obs, input data_t exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at the falling edge: whatever handshakes are up now complete at
    // the next rising edge.
    task automatic monitor();
        if (reset) return;
        if (resp_valid && resp_ready) begin
            resp_count++;
            chk("resp_expected", data_t'(exp_q.size() != 0), data_t'(1));
            if (exp_q.size() != 0) begin
                chk("resp_data", resp_rdata, exp_q.pop_front());
            end
        end
        if (req_valid && req_ready) begin
            if (req_write) begin
                for (int l = 0; l < LANES; l++) begin
                    if (req_wmask[l]) begin
                        ref_mem[req_addr][l*LANE_W +: LANE_W] = req_wdata[l*LANE_W +: LANE_W];
                    end
                end
                $display("txn: write addr=%02h mask=%b", req_addr, req_wmask);
            end else begin
                exp_q.push_back(ref_mem[req_addr]);
                rd_accepts++;
                $display("txn: read  addr=%02h outstanding=%0d", req_addr, exp_q.size());
                chk("fifo_no_overflow", data_t'(exp_q.size() <= 3), data_t'(1));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wmask = '0;
    endtask

    task automatic drive(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [LANES-1:0] m, input data_t d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wmask = m;
        req_wdata = d;
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        idle_req();
        #1;
        chk("rst_req_ready", data_t'(req_ready), data_t'(0));
        chk("rst_resp_valid", data_t'(resp_valid), data_t'(0));
        chk("rst_sram_en", data_t'(sram_en), data_t'(0));
        chk("rst_init_done", data_t'(init_done), data_t'(0));
        for (int i = 0; i < ncyc; i++) cycle();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_init(input int ncyc);
        int bad;
        bad = 0;
        for (int k = 0; k < ncyc; k++) begin
            #1;
            if (!(sram_en === 1'b1 && sram_wmode === 1'b1 && sram_addr === ADDR_W'(k) &&
                  sram_wmask === 4'hF && sram_wdata === '0 && req_ready === 1'b0 &&
                  init_done === 1'b0 && resp_valid === 1'b0)) bad++;
            cycle();
        end
        $display("txn: init %0d writes, %0d bad cycles", ncyc, bad);
        chk("init_seq", data_t'(bad), data_t'(0));
    endtask

    task automatic after_init();
        #1;
        chk("init_done_high", data_t'(init_done), data_t'(1));
        chk("ready_after_init", data_t'(req_ready), data_t'(1));
        chk("idle_sram_en", data_t'(sram_en), data_t'(0));
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    endtask

    task automatic drain(input string tag);
        for (int w = 0; w < 12 && exp_q.size() != 0; w++) cycle();
        chk(tag, data_t'(exp_q.size()), data_t'(0));
    endtask

    function automatic data_t rand_data();
        data_t r;
        r = '0;
        for (int i = 0; i < 6; i++) r = (r << 32) | data_t'($urandom);
        return r;
    endfunction

    data_t d_val, w_val, exp_d;
    int    base, rc, drop;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; rd_accepts = 0; resp_count = 0;
        reset = 1'b1; resp_ready = 1'b1;
        req_addr = '0; req_wdata = '0;
        idle_req();
        @(posedge clock); #1;

        // ---- reset release and zero-fill
        do_reset(3);
        run_init(256);
        after_init();

        // ---- masked write onto zeroed entry, then read back
        d_val = rand_data();
        drive(1'b1, 8'h12, 4'b0101, d_val);
        #1;
        chk("wr_sram_en", data_t'(sram_en), data_t'(1));
        chk("wr_sram_wmode", data_t'(sram_wmode), data_t'(1));
        chk("wr_sram_addr", data_t'(sram_addr), data_t'(8'h12));
        chk("wr_sram_wmask", data_t'(sram_wmask), data_t'(4'b0101));
        chk("wr_sram_wdata", sram_wdata, d_val);
        cycle();
        drive(1'b0, 8'h12, 4'h0, '0);
        #1;
        chk("rd_sram_en", data_t'(sram_en), data_t'(1));
        chk("rd_sram_wmode", data_t'(sram_wmode), data_t'(0));
        cycle();
        idle_req();
        #1;
        chk("rd_lat_n1_valid", data_t'(resp_valid), data_t'(0));
        cycle();
        exp_d = '0;
        exp_d[0*LANE_W +: LANE_W] = d_val[0*LANE_W +: LANE_W];
        exp_d[2*LANE_W +: LANE_W] = d_val[2*LANE_W +: LANE_W];
        chk("rd_lat_n2_valid", data_t'(resp_valid), data_t'(1));
        chk("masked_rdata", resp_rdata, exp_d);
        cycle();

        // ---- populate a small region with partial writes
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, ADDR_W'(8'h20 + i), LANES'($urandom_range(1, 15)), rand_data());
            cycle();
        end
        idle_req();

        // ---- 100 back-to-back reads at full response bandwidth
        base = rd_accepts; rc = resp_count; drop = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, ADDR_W'($urandom_range(8'h10, 8'h30)), 4'h0, '0);
            #1;
            if (req_ready !== 1'b1) drop++;
            cycle();
        end
        idle_req();
        drain("b2b_drained");
        chk("b2b_accepts", data_t'(rd_accepts - base), data_t'(100));
        chk("b2b_resps", data_t'(resp_count - rc), data_t'(100));
        chk("b2b_ready_drop", data_t'(drop), data_t'(0));

        // ---- backpressure: only three reads fit
        resp_ready = 1'b0;
        base = rd_accepts;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, ADDR_W'(8'h20 + i), 4'h0, '0);
            cycle();
        end
        #1;
        chk("bp_ready_low", data_t'(req_ready), data_t'(0));
        chk("bp_accepts", data_t'(rd_accepts - base), data_t'(3));
        chk("bp_resp_valid", data_t'(resp_valid), data_t'(1));
        idle_req();
        resp_ready = 1'b1;
        rc = resp_count;
        drain("bp_drained");
        chk("bp_resps", data_t'(resp_count - rc), data_t'(3));
        #1;
        chk("bp_ready_resume", data_t'(req_ready), data_t'(1));
        drive(1'b0, 8'h21, 4'h0, '0);
        #1;
        chk("bp_accept_resume", data_t'(sram_en), data_t'(1));
        cycle();
        idle_req();
        drain("resume_drained");

        // ---- write then read 0xFF in consecutive cycles
        w_val = rand_data();
        drive(1'b1, 8'hFF, 4'hF, w_val);
        cycle();
        drive(1'b0, 8'hFF, 4'h0, '0);
        cycle();
        idle_req();
        cycle();
        chk("raw_valid", data_t'(resp_valid), data_t'(1));
        chk("raw_rdata", resp_rdata, w_val);
        cycle();

        // ---- zero-mask write is accepted without touching the SRAM
        drive(1'b1, 8'hFF, 4'h0, ~w_val);
        #1;
        chk("wm0_sram_en", data_t'(sram_en), data_t'(0));
        chk("wm0_accepted", data_t'(req_ready), data_t'(1));
        cycle();
        drive(1'b0, 8'hFF, 4'h0, '0);
        cycle();
        idle_req();
        drain("wm0_drained");
        #1;
        chk("idle_sram_en2", data_t'(sram_en), data_t'(0));

        // ---- reset with reads outstanding, then reset mid-INIT
        resp_ready = 1'b0;
        drive(1'b0, 8'h20, 4'h0, '0);
        cycle();
        drive(1'b0, 8'h21, 4'h0, '0);
        cycle();
        idle_req();
        chk("pre_rst_outstanding", data_t'(exp_q.size()), data_t'(2));
        do_reset(2);
        resp_ready = 1'b1;
        run_init(100);
        #1;
        chk("mid_init_addr", data_t'(sram_addr), data_t'(100));
        chk("mid_init_done", data_t'(init_done), data_t'(0));
        do_reset(2);
        run_init(256);
        after_init();

        // ---- contents re-zeroed by INIT
        drive(1'b0, 8'h12, 4'h0, '0);
        cycle();
        drive(1'b0, 8'hFF, 4'h0, '0);
        cycle();
        idle_req();
        drain("final_drained");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
